// File: rtl/seq_match_sched_pkg.sv
// rtl/seq_match_sched_pkg.sv - shared types and constants for seq_match_sched
// Contents: scheduler FSM state enum, default idle-timeout and timer width,
// reset value of the latched match pattern.
package seq_match_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int TIMEOUT_DEF = 64;
  // Minimum idle-timer width; the top widens it if its TIMEOUT needs more.
  localparam int TIMEOUT_W = $clog2(TIMEOUT_DEF + 1);

  localparam logic [3:0] DEF_PATTERN = 4'b0110;

endpackage

// File: rtl/seq_match_sched_pat_matcher.sv
// rtl/seq_match_sched_pat_matcher.sv - serial masked pattern matcher with saturating count
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   clr                   start of frame: latch cfg, clear window/fill/match/count
//   cfg_pattern, cfg_mask pattern (MSB = oldest bit) and compare mask, sampled on clr
//   bit_valid, bit_in     serial bit and its qualifier
//   hit                   combinational match for the current bit
//   match                 hit registered (one-cycle pulse)
//   cnt                   saturating matches since clr
module pat_matcher
  import seq_match_sched_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             hit,
  output logic             match,
  output logic [CNT_W-1:0] cnt
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  pattern_q;
  logic [PAT_W-1:0]  mask_q;
  logic [PAT_W-2:0]  window;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  cand;

  // The incoming bit completes the window in the same cycle, so a match on
  // the last bit of a frame is seen before the frame closes.
  assign cand = {window, bit_in};
  assign hit  = bit_valid
             && ((cand & mask_q) == (pattern_q & mask_q))
             && (fill >= FILL_W'(PAT_W - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pattern_q <= PAT_W'(DEF_PATTERN);
      mask_q    <= '0;
      window    <= '0;
      fill      <= '0;
      match     <= 1'b0;
      cnt       <= '0;
    end else if (clr) begin
      pattern_q <= cfg_pattern;
      mask_q    <= cfg_mask;
      window    <= '0;
      fill      <= '0;
      match     <= 1'b0;
      cnt       <= '0;
    end else begin
      match <= hit;
      if (bit_valid) begin
        window <= cand[PAT_W-2:0];
        if (fill != FILL_W'(PAT_W)) fill <= fill + 1'b1;
      end
      if (hit && (cnt != '1)) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_match_sched.sv
// rtl/seq_match_sched.sv - round-robin scheduler sharing one pattern matcher among N serial channels
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req[N]                          per-channel frame request (level)
//   din/din_valid/din_last[N]       per-channel serial bit, qualifier, last marker
//   cfg_pattern, cfg_mask           matcher config, latched at grant
//   grant[N], busy                  one-hot grant, engine in use
//   match, match_ch                 per-bit match pulse and its channel
//   frame_done, frame_err,
//   frame_ch, frame_cnt             end-of-frame pulse, timeout flag, channel, match count
module seq_match_sched
  import seq_match_sched_pkg::*;
#(
  parameter int N       = 4,
  parameter int PAT_W   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CH_W    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     din,
  input  logic [N-1:0]     din_valid,
  input  logic [N-1:0]     din_last,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [PAT_W-1:0] cfg_mask,
  output logic [N-1:0]     grant,
  output logic             busy,
  output logic             match,
  output logic [CH_W-1:0]  match_ch,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CH_W-1:0]  frame_ch,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int TMR_W = ($clog2(TIMEOUT + 1) > TIMEOUT_W) ? $clog2(TIMEOUT + 1) : TIMEOUT_W;

  sched_state_t    state;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] gidx;
  logic [TMR_W-1:0] timer;
  logic [CH_W-1:0] pick;
  logic [CH_W-1:0] cand_ch;
  logic            pick_found;
  logic            start;
  logic            cur_valid;
  logic            cur_bit;
  logic            cur_last;
  logic            hit;

  // First requester after the last granted channel, wrapping; the channel
  // just served is examined last, which gives the fairness guarantee.
  always_comb begin
    pick_found = 1'b0;
    pick       = '0;
    cand_ch    = '0;
    for (int i = 1; i <= N; i++) begin
      cand_ch = CH_W'((int'(ptr) + i) % N);
      if (!pick_found && req[cand_ch]) begin
        pick_found = 1'b1;
        pick       = cand_ch;
      end
    end
  end

  assign start     = (state == IDLE) && pick_found;
  assign cur_valid = (state == RUN) && din_valid[gidx];
  assign cur_bit   = din[gidx];
  assign cur_last  = din_last[gidx];

  pat_matcher #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) u_matcher (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (start),
    .cfg_pattern (cfg_pattern),
    .cfg_mask    (cfg_mask),
    .bit_valid   (cur_valid),
    .bit_in      (cur_bit),
    .hit         (hit),
    .match       (match),
    .cnt         (frame_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= CH_W'(N - 1);
      gidx       <= '0;
      timer      <= '0;
      grant      <= '0;
      busy       <= 1'b0;
      match_ch   <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_ch   <= '0;
    end else begin
      match_ch   <= hit ? gidx : '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      frame_ch   <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            ptr   <= pick;
            gidx  <= pick;
            grant <= N'(1) << pick;
            busy  <= 1'b1;
            timer <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (cur_valid) begin
            timer <= '0;
            if (cur_last) begin
              grant      <= '0;
              frame_done <= 1'b1;
              frame_ch   <= gidx;
              state      <= DONE;
            end
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            grant      <= '0;
            frame_done <= 1'b1;
            frame_err  <= 1'b1;
            frame_ch   <= gidx;
            state      <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
